// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-transfer opcodes and the
// branch sequencer state type.
package cpu_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam logic [4:0] OP_JAL = 5'b10011;
  localparam logic [4:0] OP_JR  = 5'b10100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_PCY,
    S_ADD,
    S_COMMIT,
    S_LINK,
    S_JLOAD,
    S_DONE
  } bseq_state_t;

endpackage

// File: rtl/branch_sequencer.sv
// Multi-cycle sequencer for br/jr/jal: drives datapath strobes,
// decides PC write from con, counts taken transfers.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             illegal,
  output logic             gra,
  output logic             rout,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             link_in,
  output logic [CNT_W-1:0] taken_count
);

  bseq_state_t state_q, state_d;
  logic [31:0] ir_q;
  logic        taken_q;
  logic        illegal_q;
  logic [4:0]  op_q;
  logic [4:0]  op_in;
  logic        cnt_inc;
  logic        unused_ir_q;

  assign op_q  = ir_q[OP_MSB:OP_LSB];
  assign op_in = ir[OP_MSB:OP_LSB];

  // Only the opcode of the latched copy matters past acceptance.
  assign illegal_q   = !(op_q inside {OP_BR, OP_JR, OP_JAL});
  assign unused_ir_q = ^ir_q[OP_LSB-1:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ir_q    <= ir;
            taken_q <= 1'b0;
          end
        end
        S_COMMIT: taken_q <= con;
        S_JLOAD:  taken_q <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign cnt_inc = (state_q == S_COMMIT && con) ||
                   (state_q == S_JLOAD);

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      taken_count <= '0;
    else if (cnt_inc && taken_count != '1)
      taken_count <= taken_count + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    taken    = 1'b0;
    illegal  = 1'b0;
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    link_in  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op_in)
            OP_BR:   state_d = S_COND;
            OP_JR:   state_d = S_JLOAD;
            OP_JAL:  state_d = S_LINK;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_COND: begin
        gra     = 1'b1;
        rout    = 1'b1;
        con_in  = 1'b1;
        state_d = S_PCY;
      end
      S_PCY: begin
        pc_out  = 1'b1;
        y_in    = 1'b1;
        state_d = S_ADD;
      end
      S_ADD: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        zlow_out = 1'b1;
        pc_in    = con;
        state_d  = S_DONE;
      end
      S_LINK: begin
        pc_out  = 1'b1;
        link_in = 1'b1;
        state_d = S_JLOAD;
      end
      S_JLOAD: begin
        gra     = 1'b1;
        rout    = 1'b1;
        pc_in   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        taken   = taken_q;
        illegal = illegal_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed and random
// instructions against a per-opcode strobe schedule model.
module tb_branch_sequencer;
  import cpu_pkg::*;

  localparam logic [10:0] G  = 11'h400;
  localparam logic [10:0] R  = 11'h200;
  localparam logic [10:0] CI = 11'h100;
  localparam logic [10:0] PO = 11'h080;
  localparam logic [10:0] YI = 11'h040;
  localparam logic [10:0] CO = 11'h020;
  localparam logic [10:0] AA = 11'h010;
  localparam logic [10:0] ZI = 11'h008;
  localparam logic [10:0] ZL = 11'h004;
  localparam logic [10:0] PI = 11'h002;
  localparam logic [10:0] LI = 11'h001;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        con   = 1'b0;
  logic [31:0] ir    = '0;
  logic        busy, done, taken, illegal;
  logic        gra, rout, con_in, pc_out, y_in, c_out;
  logic        alu_add, z_in, zlow_out, pc_in, link_in;
  logic [15:0] taken_count;

  logic        clear2 = 1'b1;
  logic        start2 = 1'b0;
  logic [31:0] ir2    = '0;
  logic        busy2, done2, taken2, illegal2;
  logic        gra2, rout2, con_in2, pc_out2, y_in2, c_out2;
  logic        alu_add2, z_in2, zlow_out2, pc_in2, link_in2;
  logic [1:0]  taken_count2;

  logic [10:0] sv;
  assign sv = {gra, rout, con_in, pc_out, y_in, c_out,
               alu_add, z_in, zlow_out, pc_in, link_in};

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  always #5 clock = ~clock;

  branch_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .con(con), .busy(busy), .done(done), .taken(taken),
    .illegal(illegal), .gra(gra), .rout(rout),
    .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
    .c_out(c_out), .alu_add(alu_add), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .link_in(link_in),
    .taken_count(taken_count)
  );

  branch_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .clear(clear2), .start(start2), .ir(ir2),
    .con(1'b0), .busy(busy2), .done(done2), .taken(taken2),
    .illegal(illegal2), .gra(gra2), .rout(rout2),
    .con_in(con_in2), .pc_out(pc_out2), .y_in(y_in2),
    .c_out(c_out2), .alu_add(alu_add2), .z_in(z_in2),
    .zlow_out(zlow_out2), .pc_in(pc_in2), .link_in(link_in2),
    .taken_count(taken_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Executes one instruction and checks every cycle up to done.
  task automatic run(input logic [31:0] instr, input logic c,
                     input bit hold_start);
    logic [10:0] sched[$];
    logic [4:0]  op;
    logic [31:0] rnd;
    bit          tk;
    bit          il;
    int          n;
    int          dones;
    op = instr[31:27];
    sched = {};
    tk = 1'b0;
    il = 1'b0;
    if (op == OP_BR) begin
      sched.push_back(G | R | CI);
      sched.push_back(PO | YI);
      sched.push_back(CO | AA | ZI);
      sched.push_back(ZL | (c ? PI : 11'h000));
      tk = c;
    end else if (op == OP_JR) begin
      sched.push_back(G | R | PI);
      tk = 1'b1;
    end else if (op == OP_JAL) begin
      sched.push_back(PO | LI);
      sched.push_back(G | R | PI);
      tk = 1'b1;
    end else begin
      il = 1'b1;
    end
    if (tk && model_count < 65535) model_count++;
    ir = instr;
    con = c;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    n = sched.size() + 1;
    dones = 0;
    for (int k = 1; k <= n; k++) begin
      if (k < n) chk("strobes", 32'(sv), 32'(sched[k-1]));
      else chk("strobes_done", 32'(sv), 32'h0);
      chk("busy", 32'(busy), 32'h1);
      chk("done", 32'(done), 32'(k == n));
      if (done) dones++;
      if (k == n) begin
        chk("taken", 32'(taken), 32'(tk));
        chk("illegal", 32'(illegal), 32'(il));
        chk("count", 32'(taken_count), 32'(model_count));
        start = 1'b0;
      end
      rnd = $urandom;
      ir = rnd;
      step();
    end
    chk("one_done", 32'(dones), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_done", 32'(done), 32'h0);
  endtask

  initial begin
    automatic logic [31:0] rnd;
    automatic logic [4:0]  op;
    automatic int          sat_exp[5] = '{1, 2, 3, 3, 3};

    #2;
    chk("rst_strobes", 32'(sv), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_taken", 32'(taken), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_count", 32'(taken_count), 32'h0);
    @(negedge clock);
    clear = 1'b0;
    clear2 = 1'b0;

    run(32'h9080_0010, 1'b1, 1'b0);
    run(32'h9080_0010, 1'b0, 1'b0);
    run({OP_JAL, 27'h123_4567}, 1'b0, 1'b0);
    run({OP_JR, 27'h000_0040}, 1'b1, 1'b0);
    run(32'h0000_0000, 1'b1, 1'b0);
    run(32'h9080_0010, 1'b1, 1'b1);
    run({OP_JAL, 27'h0}, 1'b0, 1'b1);

    // Asynchronous clear in the middle of S_ADD.
    ir = 32'h9080_0010;
    con = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("add_strobes", 32'(sv), 32'(CO | AA | ZI));
    #2;
    clear = 1'b1;
    #1;
    chk("clr_strobes", 32'(sv), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    chk("clr_count", 32'(taken_count), 32'h0);
    model_count = 0;
    @(negedge clock);
    clear = 1'b0;
    run(32'h9080_0010, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0: op = OP_BR;
        1: op = OP_JR;
        2: op = OP_JAL;
        default: op = rnd[4:0];
      endcase
      run({op, rnd[31:5]}, 1'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5; i++) begin
      ir2 = {OP_JR, 27'h0};
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      step();
      chk("sat_done", 32'(done2), 32'h1);
      chk("sat_count", 32'(taken_count2), 32'(sat_exp[i]));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
